uart_tx_scheduler: RTL and testbench

- Sequences the UART transmitter and shares it between two byte producers.
- Round-robin arbitrates two valid/ready request ports into a small TX FIFO.
- Pops one byte at a time, drives the transmitter's holding register and status word, and times each frame from the configured frame format and bit period.
- The transmitter has no busy output, so this block owns frame timing.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the sequencer state encoding, the tx_status bit-field positions,
// the data-bit clamp limits and a helper that computes frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam int TX_EN_BIT = 0;
  localparam int FRAME_LSB = 1;
  localparam int FRAME_MSB = 7;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;

  // Total bits on the line for one character: start + data + parity + stop.
  // Stop field 0x/1x maps to 1/2 stop bits, so only its upper bit matters.
  function automatic logic [3:0] frame_bits(input logic [6:0] cfg);
    logic [3:0] data_bits;
    data_bits = cfg[3:0];
    if (data_bits < DATA_BITS_MIN) begin
      data_bits = DATA_BITS_MIN;
    end else if (data_bits > DATA_BITS_MAX) begin
      data_bits = DATA_BITS_MAX;
    end
    return 4'd1 + data_bits + {3'b000, cfg[4]} + (cfg[6] ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO for queued TX bytes.
// Ports: clk, rst_n (async active-low flush), push/push_data, pop,
// pop_data (current head), full, empty, count (occupancy 0..DEPTH).
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a flush only has to clear the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between two byte producers.
// Ports: clk, rst_n; enable gates new frames; cfg_frame/cfg_divisor give
// frame format and clocks per bit; req0/req1 valid/data/ready producer
// ports; thr_data and tx_status drive the transmitter; busy, fifo_count
// and frame_done report progress.
// The transmitter has no busy output, so frame timing is owned here.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [6:0]                 cfg_frame,
  input  logic [DIV_W-1:0]           cfg_divisor,
  input  logic                       req0_valid,
  input  logic [DATA_W-1:0]          req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [DATA_W-1:0]          req1_data,
  output logic                       req1_ready,
  output logic [31:0]                thr_data,
  output logic [31:0]                tx_status,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       frame_done
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [31:0]       thr_q, thr_d;
  logic [6:0]        frame_q, frame_d;
  logic [3:0]        fbits_q, fbits_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cyc_q, cyc_d;
  logic [3:0]        bit_q, bit_d;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head, push_data;
  logic              grant0, grant1, last_cyc;

  // prio_q=1 means requester 1 is favoured when both are valid.
  // full is a registered FIFO flag, so a same-cycle pop never frees a slot.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~prio_q);
    grant1     = req1_valid & (~req0_valid |  prio_q);
    req0_ready = grant0 & ~fifo_full;
    req1_ready = grant1 & ~fifo_full;
    fifo_push  = req0_ready | req1_ready;
    push_data  = req1_ready ? req1_data : req0_data;
    prio_d     = prio_q;
    if (req0_ready) prio_d = 1'b1;
    else if (req1_ready) prio_d = 1'b0;
  end

  assign fifo_pop = (state_q == LOAD);

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign last_cyc = (cyc_q == div_q - DIV_W'(1));

  // Frame sequencer. Config is sampled only in LOAD so changes mid-frame
  // take effect on the following character.
  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    frame_d    = frame_q;
    fbits_d    = fbits_q;
    div_d      = div_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        thr_d   = 32'(fifo_head);
        frame_d = cfg_frame;
        fbits_d = frame_bits(cfg_frame);
        div_d   = (cfg_divisor == '0) ? DIV_W'(1) : cfg_divisor;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (last_cyc) begin
          cyc_d = '0;
          if (bit_q == fbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = GUARD;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + DIV_W'(1);
        end
      end
      GUARD: begin
        if (last_cyc) begin
          cyc_d      = '0;
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          cyc_d = cyc_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      thr_q   <= '0;
      frame_q <= '0;
      fbits_q <= '0;
      div_q   <= DIV_W'(1);
      cyc_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      thr_q   <= thr_d;
      frame_q <= frame_d;
      fbits_q <= fbits_d;
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    tx_status                      = '0;
    tx_status[FRAME_MSB:FRAME_LSB] = frame_q;
    tx_status[TX_EN_BIT]           = (state_q == SEND);
  end

  assign thr_data = thr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler.
module tb_uart_tx_scheduler;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [6:0]        cfg_frame;
  logic [DIV_W-1:0]  cfg_divisor;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [31:0]       thr_data, tx_status;
  logic              busy, frame_done;
  logic [2:0]        fifo_count;

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_frame   (cfg_frame),
    .cfg_divisor (cfg_divisor),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .thr_data    (thr_data),
    .tx_status   (tx_status),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .frame_done  (frame_done)
  );

  // Drives the configuration inputs.
  task automatic applyStimulus(input logic en, input logic [6:0] cfg, input int div);
    enable      = en;
    cfg_frame   = cfg;
    cfg_divisor = DIV_W'(div);
  endtask

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Moves to the next falling edge and lets inputs/combinational outputs settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offers one byte on a port and holds it until accepted (bounded).
  task automatic pushByte(input int port, input logic [7:0] d);
    int n;
    if (port == 0) begin req0_valid = 1'b1; req0_data = d; end
    else begin req1_valid = 1'b1; req1_data = d; end
    #1;
    n = 0;
    while (!((port == 0) ? req0_ready : req1_ready) && n < 50) begin
      step();
      n++;
    end
    checkOutput("push_accept", 32'(n < 50), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
  endtask

  // Observes one transmit window and the guard that follows it.
  // actKind 1 drops enable, 2 scrambles the config, at window cycle actAt.
  task automatic runFrame(input int actAt, input int actKind,
                          output int pre, output int win, output int guard,
                          output int pulses, output logic [31:0] thrS,
                          output logic [31:0] stS, output logic [31:0] stG);
    pre = 0; win = 0; guard = 0; pulses = 0;
    while (!tx_status[0] && pre < 300) begin
      pre++;
      step();
    end
    thrS = thr_data;
    stS  = tx_status;
    while (tx_status[0] && win < 300) begin
      if (win == actAt && actKind == 1) enable = 1'b0;
      if (win == actAt && actKind == 2) applyStimulus(enable, 7'b1110001, 7);
      pulses += int'(frame_done);
      win++;
      step();
    end
    stG = tx_status;
    while (busy && !tx_status[0] && guard < 300) begin
      pulses += int'(frame_done);
      guard++;
      step();
    end
  endtask

  initial begin
    int pre, win, guard, pulses, n;
    logic [31:0] thrS, stS, stG;
    logic [7:0] expThr [4];

    rst_n = 1'b0;
    applyStimulus(0, 7'b0, 0);
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    repeat (2) step();
    checkOutput("rst_thr", thr_data, 32'h0);
    checkOutput("rst_status", tx_status, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step();

    // 8N1 at 4 clocks per bit: 10 bits -> 40-cycle window, 4-cycle guard.
    $display("[TB] single byte 8N1");
    applyStimulus(1, 7'b01_0_1000, 4);
    pushByte(0, 8'h50);
    runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("8n1_thr", thrS, 32'h50);
    checkOutput("8n1_status_tx", stS, 32'h51);
    checkOutput("8n1_window", 32'(win), 32'd40);
    checkOutput("8n1_status_guard", stG, 32'h50);
    checkOutput("8n1_guard", 32'(guard), 32'd4);
    checkOutput("8n1_done_pulses", 32'(pulses), 32'd1);
    checkOutput("8n1_count", 32'(fifo_count), 32'd0);

    // 8E2 at 3: 12 bits -> 36. Data field 12 clamps to 8.
    $display("[TB] 8E2 and clamp");
    applyStimulus(1, 7'b10_1_1000, 3);
    pushByte(1, 8'h11);
    runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("8e2_thr", thrS, 32'h11);
    checkOutput("8e2_status", stS, 32'hB1);
    checkOutput("8e2_window", 32'(win), 32'd36);
    checkOutput("8e2_guard", 32'(guard), 32'd3);
    applyStimulus(1, 7'b10_1_1100, 3);
    pushByte(1, 8'h22);
    runFrame(5, 2, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("clamp_thr", thrS, 32'h22);
    checkOutput("clamp_status", stS, 32'hB9);
    checkOutput("clamp_window_cfgchg", 32'(win), 32'd36);
    checkOutput("clamp_guard_cfgchg", 32'(guard), 32'd3);

    // Round robin filling to full with enable low; last push was req1.
    $display("[TB] round robin fill");
    applyStimulus(0, 7'b00_0_0011, 0);
    req0_valid = 1'b1; req0_data = 8'hA0;
    req1_valid = 1'b1; req1_data = 8'hB0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_ready0_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
      checkOutput($sformatf("rr_ready1_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
      step();
      if (k == 0) req0_data = 8'hA1;
      if (k == 1) req1_data = 8'hB1;
      if (k == 2) req0_data = 8'hA2;
      if (k == 3) req1_data = 8'hB2;
      #1;
    end
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    checkOutput("full_ready0", 32'(req0_ready), 32'd0);
    checkOutput("full_ready1", 32'(req1_ready), 32'd0);
    checkOutput("disabled_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_count", 32'(fifo_count), 32'd4);
    checkOutput("load_ready0", 32'(req0_ready), 32'd0);
    checkOutput("load_ready1", 32'(req1_ready), 32'd0);
    step();
    checkOutput("after_pop_count", 32'(fifo_count), 32'd3);
    checkOutput("after_pop_ready0", 32'(req0_ready), 32'd1);
    checkOutput("after_pop_ready1", 32'(req1_ready), 32'd0);
    checkOutput("first_thr", thr_data, 32'hA0);
    checkOutput("first_status", tx_status, 32'h07);
    step();
    checkOutput("refill_count", 32'(fifo_count), 32'd4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (tx_status[0] && n < 100) begin step(); n++; end
    checkOutput("first_window_end", 32'(n < 100), 32'd1);
    expThr[0] = 8'hB0; expThr[1] = 8'hA1; expThr[2] = 8'hB1; expThr[3] = 8'hA2;
    for (int i = 0; i < 4; i++) begin
      runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
      checkOutput($sformatf("rr_thr_%0d", i), thrS, 32'(expThr[i]));
      checkOutput($sformatf("rr_window_%0d", i), 32'(win), 32'd7);
      checkOutput($sformatf("rr_done_%0d", i), 32'(pulses), 32'd1);
      if (i > 0) checkOutput($sformatf("rr_gap_%0d", i), 32'(guard + pre), 32'd3);
    end

    // Enable gating, back-to-back gap of divisor+2 and a mid-SEND drop.
    $display("[TB] enable control");
    applyStimulus(0, 7'b01_0_1000, 2);
    pushByte(0, 8'h61);
    pushByte(0, 8'h62);
    pushByte(0, 8'h63);
    pushByte(0, 8'h64);
    repeat (5) step();
    checkOutput("gated_busy", 32'(busy), 32'd0);
    checkOutput("gated_count", 32'(fifo_count), 32'd4);
    enable = 1'b1;
    runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("en_thr0", thrS, 32'h61);
    checkOutput("en_window0", 32'(win), 32'd20);
    runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("en_thr1", thrS, 32'h62);
    checkOutput("en_gap1", 32'(guard + pre), 32'd4);
    runFrame(5, 1, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("drop_thr", thrS, 32'h63);
    checkOutput("drop_window", 32'(win), 32'd20);
    checkOutput("drop_guard", 32'(guard), 32'd2);
    checkOutput("drop_done", 32'(pulses), 32'd1);
    repeat (10) step();
    checkOutput("drop_idle_busy", 32'(busy), 32'd0);
    checkOutput("drop_idle_count", 32'(fifo_count), 32'd1);
    checkOutput("drop_thr_hold", thr_data, 32'h63);
    checkOutput("drop_idle_status", tx_status, 32'h50);

    // Asynchronous reset in the middle of a frame.
    $display("[TB] reset mid-frame");
    applyStimulus(1, 7'b01_0_1000, 4);
    n = 0;
    while (!tx_status[0] && n < 100) begin step(); n++; end
    checkOutput("mid_reset_started", 32'(n < 100), 32'd1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_status", tx_status, 32'h0);
    checkOutput("arst_thr", thr_data, 32'h0);
    checkOutput("arst_count", 32'(fifo_count), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    pushByte(1, 8'h99);
    runFrame(-1, 0, pre, win, guard, pulses, thrS, stS, stG);
    checkOutput("post_rst_thr", thrS, 32'h99);
    checkOutput("post_rst_status", stS, 32'h51);
    checkOutput("post_rst_window", 32'(win), 32'd40);
    checkOutput("post_rst_done", 32'(pulses), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
